seg7_serial_driver: RTL and testbench

Serial driver for the board's eight-digit seven-segment display. It captures a 32-bit word as eight hex nibbles on each refresh request and decodes every nibble to an active-low segment byte. It then shifts the resulting 64 bits into the board's external shift-register chain and pulses a latch strobe. It sits at the top level next to the VGA path and shows the game score.

---
 rtl/seg7_serial_driver_pkg.sv | 29 ++
 rtl/seg7_hex_decode.sv | 19 +
 rtl/seg7_serial_driver.sv | 163 ++++++++++++++++
 tb/tb_seg7_serial_driver.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_serial_driver_pkg.sv
// ============================================================================
// Module      : seg7_serial_driver_pkg
// Description : Shared types and the hex-to-segment table for the
//               seven-segment display path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg7_serial_driver_pkg;

  // Frame sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_e;

  // Active-low segment bytes {a,b,c,d,e,f,g,dp}; entry [n] is hex digit n.
  // The decimal point bit is always 1 (off).
  localparam logic [15:0][7:0] C_SEG_TABLE = {
    8'h71, 8'h61, 8'h85, 8'h63,   // F E d C
    8'hC1, 8'h11, 8'h09, 8'h01,   // b A 9 8
    8'h1F, 8'h41, 8'h49, 8'h99,   // 7 6 5 4
    8'h0D, 8'h25, 8'h9F, 8'h03    // 3 2 1 0
  };

endpackage

`default_nettype wire

// File: rtl/seg7_hex_decode.sv
// ============================================================================
// Module      : seg7_hex_decode
// Description : Combinational 4-bit hex nibble to active-low segment byte.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_hex_decode
  import seg7_serial_driver_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [7:0] seg_o
);

  assign seg_o = C_SEG_TABLE[hex_i];

endmodule

`default_nettype wire

// File: rtl/seg7_serial_driver.sv
// ============================================================================
// Module      : seg7_serial_driver
// Description : Captures a 32-bit value as eight hex digits, decodes them to
//               segment bytes and shifts the 64 bits into the external
//               display shift-register chain, then pulses the latch strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_serial_driver
  import seg7_serial_driver_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        seg_clk,
  input  logic [31:0] data,
  output logic        SEG_CLK,
  output logic        SEG_SOUT,
  output logic        SEG_PEN,
  output logic        SEG_CLRN
);

  // The divider counts up to 2*CLK_DIV-1 in the latch phase.
  localparam int                DIV_W        = (CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]  c_half_last  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]  c_latch_last = DIV_W'(2 * CLK_DIV - 1);

  logic [7:0][7:0] dec_w;
  logic [63:0]     frame_w;
  logic            rise_w;

  logic            sync1_q, sync2_q, sync3_q;
  state_e          state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [5:0]      bit_q, bit_d;
  // Holds the bits still to be sent; the bit on SEG_SOUT is not kept here,
  // so only 63 bits are needed.
  logic [62:0]     shreg_q, shreg_d;
  logic            sclk_q, sclk_d;
  logic            sout_q, sout_d;
  logic            pen_q, pen_d;
  logic            clrn_q;

  // One decoder per digit; digit 7 lands in the top byte so it shifts first.
  for (genvar gi = 0; gi < 8; gi++) begin : g_dec
    seg7_hex_decode u_dec (
      .hex_i (data[4*gi +: 4]),
      .seg_o (dec_w[gi])
    );
  end

  assign frame_w = dec_w;
  assign rise_w  = sync2_q & ~sync3_q;

  // Synchronize the refresh request and keep one extra stage for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= seg_clk;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // Frame sequencer state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      sclk_q  <= 1'b0;
      sout_q  <= 1'b0;
      pen_q   <= 1'b0;
      clrn_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      sclk_q  <= sclk_d;
      sout_q  <= sout_d;
      pen_q   <= pen_d;
      clrn_q  <= 1'b1;
    end
  end

  // Next-state logic: SEG_CLK doubles as the low/high phase flag of a slot.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    sclk_d  = sclk_q;
    sout_d  = sout_q;
    pen_d   = pen_q;

    case (state_q)
      ST_IDLE: begin
        sclk_d = 1'b0;
        pen_d  = 1'b0;
        if (rise_w) begin
          state_d = ST_SHIFT;
          div_d   = '0;
          bit_d   = '0;
          sout_d  = frame_w[63];
          shreg_d = frame_w[62:0];
        end
      end

      ST_SHIFT: begin
        if (div_q == c_half_last) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else if (bit_q == 6'd63) begin
            state_d = ST_LATCH;
            sclk_d  = 1'b0;
            pen_d   = 1'b1;
          end else begin
            // New data appears together with the falling SEG_CLK edge.
            sclk_d  = 1'b0;
            bit_d   = bit_q + 6'd1;
            sout_d  = shreg_q[62];
            shreg_d = {shreg_q[61:0], 1'b0};
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      ST_LATCH: begin
        sclk_d = 1'b0;
        if (div_q == c_latch_last) begin
          state_d = ST_IDLE;
          div_d   = '0;
          pen_d   = 1'b0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        sclk_d  = 1'b0;
        pen_d   = 1'b0;
      end
    endcase
  end

  assign SEG_CLK  = sclk_q;
  assign SEG_SOUT = sout_q;
  assign SEG_PEN  = pen_q;
  assign SEG_CLRN = clrn_q;

endmodule

`default_nettype wire

// File: tb/tb_seg7_serial_driver.sv
// ============================================================================
// Module      : tb_seg7_serial_driver
// Description : Self-checking bench for seg7_serial_driver with CLK_DIV=4
//               (instance A) and CLK_DIV=1 (instance B).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_serial_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        seg_clk_a = 1'b0;
  logic        seg_clk_b = 1'b0;
  logic [31:0] data = '0;
  logic        a_sclk, a_sout, a_pen, a_clrn;
  logic        b_sclk, b_sout, b_pen, b_clrn;

  int n_checks = 0;
  int n_fail   = 0;

  // Segment patterns as listed for digits 0..F.
  logic [7:0] seg_of [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                              8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

  always #5 clk = ~clk;

  seg7_serial_driver #(.CLK_DIV(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .seg_clk(seg_clk_a), .data(data),
    .SEG_CLK(a_sclk), .SEG_SOUT(a_sout), .SEG_PEN(a_pen), .SEG_CLRN(a_clrn)
  );

  seg7_serial_driver #(.CLK_DIV(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .seg_clk(seg_clk_b), .data(data),
    .SEG_CLK(b_sclk), .SEG_SOUT(b_sout), .SEG_PEN(b_pen), .SEG_CLRN(b_clrn)
  );

  // Reference: digit 7 first, each byte MSB first.
  function automatic logic [63:0] expect_stream(input logic [31:0] d);
    logic [63:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) r = {r[55:0], seg_of[d[4*i +: 4]]};
    return r;
  endfunction

  task automatic drive(input int which, input logic v);
    if (which != 0) seg_clk_b = v;
    else            seg_clk_a = v;
  endtask

  // Issues one refresh request and records what the chain would see.
  // Length is first SEG_CLK-high cycle to last SEG_PEN cycle inclusive,
  // i.e. the whole frame minus the first low phase.
  task automatic monitor(input int which, input int cdiv, input int pulse_at,
                         input int change_at, input logic [31:0] new_data,
                         output logic [63:0] bits, output int rises, output int pen_cyc,
                         output int pen_pulses, output int length, output int latency,
                         output int viol, output int extra, output bit to);
    logic c, s, p, pc, ps, pp;
    int   n, first_hi, last_pen, hi_run, lo_run, tail, pulse_n;
    bit   done;
    bits = '0; rises = 0; pen_cyc = 0; pen_pulses = 0; length = -1; latency = -1;
    viol = 0; extra = 0; to = 1'b0;
    first_hi = -1; last_pen = -1; hi_run = 0; lo_run = 0; tail = 0; pulse_n = -1;
    done = 1'b0; n = 0;
    pc = (which != 0) ? b_sclk : a_sclk;
    ps = (which != 0) ? b_sout : a_sout;
    pp = (which != 0) ? b_pen  : a_pen;
    @(negedge clk);
    drive(which, 1'b1);
    while (1) begin
      @(negedge clk);
      n++;
      c = (which != 0) ? b_sclk : a_sclk;
      s = (which != 0) ? b_sout : a_sout;
      p = (which != 0) ? b_pen  : a_pen;
      if (n == 10) drive(which, 1'b0);
      if (pulse_at >= 0 && pulse_n < 0 && rises == pulse_at) begin
        drive(which, 1'b1);
        pulse_n = n;
      end
      if (pulse_n >= 0 && n == pulse_n + 6) drive(which, 1'b0);
      if (change_at >= 0 && rises == change_at) data = new_data;
      if (c && !pc) begin
        if (done) extra++;
        else begin
          if (first_hi < 0) begin
            first_hi = n;
            latency  = n;
          end else if (lo_run != cdiv) viol++;
          bits = {bits[62:0], s};
          rises++;
        end
      end
      if (!c && pc && !done && hi_run != cdiv) viol++;
      if (c) hi_run = pc ? hi_run + 1 : 1;
      else   lo_run = pc ? 1 : lo_run + 1;
      if (c && s !== ps) viol++;
      if (p) begin
        pen_cyc++;
        last_pen = n;
        if (!pp) pen_pulses++;
      end
      if (!done && pp && !p) begin
        done   = 1'b1;
        length = last_pen - first_hi + 1;
      end
      if (done) begin
        tail++;
        if (tail > 4 * cdiv + 20) break;
      end
      if (n > 200 * cdiv + 100) begin
        to = 1'b1;
        break;
      end
      pc = c; ps = s; pp = p;
    end
    drive(which, 1'b0);
  endtask

  task automatic test_reset;
    int r;
    logic pc;
    rst_n = 1'b0; seg_clk_a = 1'b0; seg_clk_b = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({a_sclk, a_sout, a_pen, a_clrn} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_a: got %b expected 0000", {a_sclk, a_sout, a_pen, a_clrn});
    end
    n_checks++;
    if ({b_sclk, b_sout, b_pen, b_clrn} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_b: got %b expected 0000", {b_sclk, b_sout, b_pen, b_clrn});
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({a_clrn, b_clrn} !== 2'b11) begin
      n_fail++; $display("FAIL clrn_release: got %b expected 11", {a_clrn, b_clrn});
    end
    r = 0; pc = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if ((a_sclk && !pc) || b_sclk || a_pen || b_pen) r++;
      pc = a_sclk;
    end
    n_checks++;
    if (r !== 0) begin
      n_fail++; $display("FAIL idle_quiet: got %0d activity cycles expected 0", r);
    end
  endtask

  task automatic test_single_frame;
    logic [63:0] bits; int rises, pc, pp, len, lat, viol, ex; bit to;
    data = 32'h0123_89AF;
    monitor(0, 4, -1, -1, 32'h0, bits, rises, pc, pp, len, lat, viol, ex, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL single_timeout: got timeout expected frame end"); end
    n_checks++;
    if (bits !== 64'h039F_250D_0109_1171) begin
      n_fail++; $display("FAIL single_bits: got %h expected 039f250d01091171", bits);
    end
    n_checks++;
    if (rises !== 64) begin n_fail++; $display("FAIL single_rises: got %0d expected 64", rises); end
    n_checks++;
    if (pc !== 8 || pp !== 1) begin
      n_fail++; $display("FAIL single_pen: got %0d cycles/%0d pulses expected 8/1", pc, pp);
    end
    n_checks++;
    if (lat !== 7) begin n_fail++; $display("FAIL single_latency: got %0d expected 7", lat); end
    n_checks++;
    if (len !== 129 * 4) begin n_fail++; $display("FAIL single_length: got %0d expected %0d", len, 129 * 4); end
    n_checks++;
    if (viol !== 0) begin n_fail++; $display("FAIL single_timing: got %0d violations expected 0", viol); end
  endtask

  task automatic test_data_stability;
    logic [63:0] bits; int rises, pc, pp, len, lat, viol, ex; bit to;
    logic [31:0] d0;
    d0 = $urandom;
    data = d0;
    monitor(0, 4, -1, 30, 32'hFFFF_FFFF, bits, rises, pc, pp, len, lat, viol, ex, to);
    n_checks++;
    if (to || bits !== expect_stream(d0)) begin
      n_fail++; $display("FAIL stable_bits: got %h expected %h (timeout %0d)", bits, expect_stream(d0), to);
    end
    monitor(0, 4, -1, -1, 32'h0, bits, rises, pc, pp, len, lat, viol, ex, to);
    n_checks++;
    if (to || bits !== 64'h7171_7171_7171_7171) begin
      n_fail++; $display("FAIL stable_next: got %h expected 7171717171717171", bits);
    end
  endtask

  task automatic test_busy_request;
    logic [63:0] bits; int rises, pc, pp, len, lat, viol, ex; bit to;
    logic [31:0] d0;
    d0 = $urandom;
    data = d0;
    monitor(0, 4, 20, -1, 32'h0, bits, rises, pc, pp, len, lat, viol, ex, to);
    n_checks++;
    if (to || bits !== expect_stream(d0) || rises !== 64) begin
      n_fail++; $display("FAIL busy_bits: got %h/%0d expected %h/64", bits, rises, expect_stream(d0));
    end
    n_checks++;
    if (pp !== 1 || ex !== 0) begin
      n_fail++; $display("FAIL busy_single: got %0d pulses %0d extra rises expected 1/0", pp, ex);
    end
  endtask

  task automatic test_random_frames;
    logic [63:0] bits; int rises, pc, pp, len, lat, viol, ex; bit to;
    logic [31:0] d0;
    for (int k = 0; k < 3; k++) begin
      d0 = $urandom;
      data = d0;
      monitor(0, 4, -1, -1, 32'h0, bits, rises, pc, pp, len, lat, viol, ex, to);
      n_checks++;
      if (to || bits !== expect_stream(d0) || pp !== 1 || viol !== 0) begin
        n_fail++; $display("FAIL rand_frame: got %h pulses %0d viol %0d expected %h 1 0",
                           bits, pp, viol, expect_stream(d0));
      end
    end
  endtask

  task automatic test_clkdiv1;
    logic [63:0] bits; int rises, pc, pp, len, lat, viol, ex; bit to;
    logic [31:0] d0;
    for (int k = 0; k < 3; k++) begin
      d0 = $urandom;
      data = d0;
      monitor(1, 1, -1, -1, 32'h0, bits, rises, pc, pp, len, lat, viol, ex, to);
      n_checks++;
      if (to || bits !== expect_stream(d0)) begin
        n_fail++; $display("FAIL div1_bits: got %h expected %h", bits, expect_stream(d0));
      end
      n_checks++;
      if (viol !== 0) begin n_fail++; $display("FAIL div1_setup: got %0d violations expected 0", viol); end
      // 130-cycle frame less the first 1-cycle low phase.
      n_checks++;
      if (len !== 129 || pc !== 2 || lat !== 4) begin
        n_fail++; $display("FAIL div1_length: got len %0d pen %0d lat %0d expected 129 2 4", len, pc, lat);
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [63:0] bits; int rises, pc, pp, len, lat, viol, ex; bit to;
    logic [31:0] d0;
    logic prev;
    int   r, n, pens;
    data = $urandom;
    @(negedge clk);
    seg_clk_a = 1'b1;
    r = 0; n = 0; prev = a_sclk;
    while (r < 40 && n < 2000) begin
      @(negedge clk);
      n++;
      if (n == 10) seg_clk_a = 1'b0;
      if (a_sclk && !prev) r++;
      prev = a_sclk;
    end
    seg_clk_a = 1'b0;
    n_checks++;
    if (r !== 40) begin n_fail++; $display("FAIL midrst_reach: got %0d rises expected 40", r); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({a_sclk, a_sout, a_pen, a_clrn} !== 4'b0000) begin
      n_fail++; $display("FAIL midrst_async: got %b expected 0000", {a_sclk, a_sout, a_pen, a_clrn});
    end
    pens = 0;
    repeat (10) begin
      @(negedge clk);
      if (a_pen !== 1'b0 || a_sclk !== 1'b0) pens++;
    end
    n_checks++;
    if (pens !== 0) begin n_fail++; $display("FAIL midrst_quiet: got %0d active cycles expected 0", pens); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    d0 = $urandom;
    data = d0;
    monitor(0, 4, -1, -1, 32'h0, bits, rises, pc, pp, len, lat, viol, ex, to);
    n_checks++;
    if (to || bits !== expect_stream(d0) || pp !== 1 || rises !== 64) begin
      n_fail++; $display("FAIL midrst_next: got %h pulses %0d rises %0d expected %h 1 64",
                         bits, pp, rises, expect_stream(d0));
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_data_stability();
    test_busy_request();
    test_random_frames();
    test_clkdiv1();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
